// File: rtl/ejercicio_2_monitor.sv
// Capture/statistics stage for the Ejercicio_2 outputs X, Y, Z.
// Keeps saturating rise counters per output plus a pattern-match counter,
// and serves snapshots of any counter through a request/acknowledge port.
//
// state | meaning
// IDLE  | no enable, waiting for a read request or enable
// RUN   | sampling enabled, waiting for a read request
// RESP  | snapshot held on RD_DATA, waiting for RD_ACK
module ejercicio_2_monitor #(
  parameter int         CNT_W = 8,
  parameter logic [2:0] MATCH = 3'b111
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             X,
  input  logic             Y,
  input  logic             Z,
  input  logic             RD_REQ,
  input  logic [1:0]       RD_SEL,
  input  logic             RD_ACK,
  output logic             RD_VALID,
  output logic [CNT_W-1:0] RD_DATA,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             px_q, py_q, pz_q;
  logic             px_d, py_d, pz_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [3:0]       hit;

  // Event detection and saturating counter update; CLR wins over increments.
  always_comb begin
    hit[0] = EN & X & ~px_q;
    hit[1] = EN & Y & ~py_q;
    hit[2] = EN & Z & ~pz_q;
    hit[3] = EN & ({X, Y, Z} == MATCH);
    px_d   = EN ? X : px_q;
    py_d   = EN ? Y : py_q;
    pz_d   = EN ? Z : pz_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (CLR) begin
        cnt_d[i] = '0;
      end else if (hit[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Read-port FSM: next state, snapshot capture and valid flag.
  always_comb begin
    state_d    = state_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    case (state_q)
      S_IDLE: begin
        if (RD_REQ) begin
          state_d    = S_RESP;
          rd_data_d  = cnt_q[RD_SEL];
          rd_valid_d = 1'b1;
        end else if (EN) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (RD_REQ) begin
          state_d    = S_RESP;
          rd_data_d  = cnt_q[RD_SEL];
          rd_valid_d = 1'b1;
        end else if (!EN) begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (RD_ACK) begin
          state_d    = EN ? S_RUN : S_IDLE;
          rd_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        rd_valid_d = 1'b0;
      end
    endcase
  end

  // State, sample and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      px_q       <= 1'b0;
      py_q       <= 1'b0;
      pz_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pz_q       <= pz_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;
  assign BUSY     = (state_q == S_RESP);

endmodule
